// File: rtl/filt_iir_decim_quant.sv
// Boxcar integrate-and-dump decimator with round, shift and saturate for the filt_iir output.
// Optional overflow counter port o_sat_cnt is enabled with FILT_IIR_DECIM_SATCNT_EN.
module filt_iir_decim_quant #(
    parameter int gp_inp_width  = 16,
    parameter int gp_oup_width  = 8,
    parameter int gp_dec_factor = 4,
    parameter int gp_shift      = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst_an,
    input  logic                           i_ena,
    input  logic signed [gp_inp_width-1:0] i_data,
    output logic signed [gp_oup_width-1:0] o_data,
    output logic                           o_valid,
    output logic                           o_sat
`ifdef FILT_IIR_DECIM_SATCNT_EN
    ,
    output logic [7:0]                     o_sat_cnt
`endif
);

    localparam int acc_width = gp_inp_width + $clog2(gp_dec_factor);
    localparam int ph_width  = ($clog2(gp_dec_factor) < 1) ? 1 : $clog2(gp_dec_factor);
    localparam logic [ph_width-1:0] last_phase = ph_width'(gp_dec_factor - 1);
    localparam int rnd_pos = (gp_shift > 0) ? gp_shift - 1 : 0;
    localparam logic signed [acc_width:0] rnd_const =
        (gp_shift > 0) ? ((acc_width + 1)'(1) << rnd_pos) : '0;
    localparam logic signed [acc_width:0] q_max =
        {{(acc_width - gp_oup_width + 2){1'b0}}, {(gp_oup_width - 1){1'b1}}};
    localparam logic signed [acc_width:0] q_min =
        {{(acc_width - gp_oup_width + 2){1'b1}}, {(gp_oup_width - 1){1'b0}}};

    logic [ph_width-1:0]         phase;
    logic signed [acc_width-1:0] acc;
    logic signed [acc_width-1:0] dump;
    logic                        dump_vld;
    logic signed [acc_width-1:0] data_ext;
    logic signed [acc_width-1:0] acc_sum;
    logic signed [acc_width:0]   rnd_sum;
    logic signed [acc_width:0]   shifted;
    logic signed [gp_oup_width-1:0] q_data;
    logic                        q_sat;

    assign data_ext = {{(acc_width - gp_inp_width){i_data[gp_inp_width-1]}}, i_data};
    assign acc_sum  = acc + data_ext;

    // Stage 1: integrate D enabled samples, then hand the full sum to stage 2.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            phase    <= '0;
            acc      <= '0;
            dump     <= '0;
            dump_vld <= 1'b0;
        end else begin
            dump_vld <= 1'b0;
            if (i_ena) begin
                if (phase == last_phase) begin
                    dump     <= acc_sum;
                    dump_vld <= 1'b1;
                    acc      <= '0;
                    phase    <= '0;
                end else begin
                    acc   <= acc_sum;
                    phase <= phase + ph_width'(1);
                end
            end
        end
    end

    // One extra bit on the rounding add keeps it from wrapping at the acc extremes.
    always_comb begin
        rnd_sum = {dump[acc_width-1], dump} + rnd_const;
        shifted = rnd_sum >>> gp_shift;
        q_data  = shifted[gp_oup_width-1:0];
        q_sat   = 1'b0;
        if (shifted > q_max) begin
            q_data = {1'b0, {(gp_oup_width - 1){1'b1}}};
            q_sat  = 1'b1;
        end else if (shifted < q_min) begin
            q_data = {1'b1, {(gp_oup_width - 1){1'b0}}};
            q_sat  = 1'b1;
        end
    end

    // o_valid is a one-cycle strobe with no backpressure; o_data/o_sat are meaningful only
    // while it is high, and o_data holds its last value between strobes.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_sat   <= 1'b0;
        end else begin
            o_valid <= dump_vld;
            o_sat   <= dump_vld & q_sat;
            if (dump_vld) begin
                o_data <= q_data;
            end
        end
    end

`ifdef FILT_IIR_DECIM_SATCNT_EN
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            o_sat_cnt <= '0;
        end else if (o_valid && o_sat && (o_sat_cnt != 8'hff)) begin
            o_sat_cnt <= o_sat_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_filt_iir_decim_quant.sv
// Directed bench for filt_iir_decim_quant at default parameters (D=4, shift=2, 16->8 bits).
module tb_filt_iir_decim_quant;

    logic              i_clk = 1'b0;
    logic              i_rst_an = 1'b0;
    logic              i_ena = 1'b0;
    logic signed [15:0] i_data = '0;
    logic signed [7:0] o_data;
    logic              o_valid;
    logic              o_sat;
`ifdef FILT_IIR_DECIM_SATCNT_EN
    logic [7:0]        o_sat_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] exp_q[$];

    filt_iir_decim_quant dut (
        .i_clk    (i_clk),
        .i_rst_an (i_rst_an),
        .i_ena    (i_ena),
        .i_data   (i_data),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_sat    (o_sat)
`ifdef FILT_IIR_DECIM_SATCNT_EN
        ,
        .o_sat_cnt(o_sat_cnt)
`endif
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    // scoreboard: each o_valid pops one expected {sat, data}
    always @(negedge i_clk) begin
        logic [8:0] e;
        if (i_rst_an && o_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", int'(o_data), int'($signed(e[7:0])));
                check("sb_sat", int'(o_sat), int'(e[8]));
            end
        end
    end

    // driver tasks: inputs change 1 time unit after the edge, outputs read there too
    task automatic tick(input logic ena, input int data);
        i_ena  = ena;
        i_data = 16'(data);
        @(posedge i_clk);
        #1;
    endtask

    task automatic frame(input string tag, input int s0, input int s1, input int s2,
                         input int s3, input int exp_d, input logic exp_s);
        exp_q.push_back({exp_s, 8'(exp_d)});
        tick(1'b1, s0);
        tick(1'b1, s1);
        tick(1'b1, s2);
        tick(1'b1, s3);
        check({tag, "_no_early_valid"}, int'(o_valid), 0);
        tick(1'b0, 0);
        check({tag, "_valid"}, int'(o_valid), 1);
        check({tag, "_data"}, int'(o_data), exp_d);
        check({tag, "_sat"}, int'(o_sat), int'(exp_s));
        tick(1'b0, 0);
        check({tag, "_valid_single"}, int'(o_valid), 0);
    endtask

    initial begin
        logic [6:0] ena_pat;
        #1;
        check("rst_data", int'(o_data), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_sat", int'(o_sat), 0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst_an = 1'b1;

        // 1: basic frame
        frame("basic", 10, 10, 10, 10, 10, 1'b0);

        // 2: saturation both ways
        frame("sat_pos", 1000, 1000, 1000, 1000, 127, 1'b1);
        frame("sat_neg", -1000, -1000, -1000, -1000, -128, 1'b1);
`ifdef FILT_IIR_DECIM_SATCNT_EN
        check("sat_cnt", int'(o_sat_cnt), 2);
`endif

        // 3: rounding half toward +inf
        frame("rnd_p2", 1, 1, 0, 0, 1, 1'b0);
        frame("rnd_m2", -1, -1, 0, 0, 0, 1'b0);
        frame("rnd_m3", -1, -1, -1, 0, -1, 1'b0);

        // 4: enable gaps; only the 4th enabled sample dumps
        ena_pat = 7'b1101001;
        exp_q.push_back({1'b0, 8'd8});
        for (int k = 0; k < 7; k++) begin
            tick(ena_pat[k], 8);
            check("gap_no_valid", int'(o_valid), 0);
        end
        tick(1'b0, 0);
        check("gap_valid", int'(o_valid), 1);
        check("gap_data", int'(o_data), 8);
        tick(1'b0, 0);
        check("gap_valid_single", int'(o_valid), 0);

        // 5: reset mid-frame discards the partial sum
        tick(1'b1, 100);
        tick(1'b1, 100);
        i_ena = 1'b0;
        i_rst_an = 1'b0;
        #2;
        check("midrst_data", int'(o_data), 0);
        check("midrst_valid", int'(o_valid), 0);
        check("midrst_sat", int'(o_sat), 0);
`ifdef FILT_IIR_DECIM_SATCNT_EN
        check("midrst_sat_cnt", int'(o_sat_cnt), 0);
`endif
        @(posedge i_clk);
        #1;
        i_rst_an = 1'b1;
        frame("post_rst", 20, 20, 20, 20, 20, 1'b0);

        // 6: continuous ramp 0..7, sums 6 and 22 alternate
        for (int f = 0; f < 5; f++) exp_q.push_back({1'b0, (f % 2 == 0) ? 8'd2 : 8'd6});
        for (int k = 1; k <= 20; k++) begin
            tick(1'b1, (k - 1) % 8);
            check("ramp_valid", int'(o_valid), (k >= 5 && (k - 1) % 4 == 0) ? 1 : 0);
        end
        tick(1'b0, 0);
        check("ramp_last_valid", int'(o_valid), 1);
        check("ramp_last_data", int'(o_data), 2);
        tick(1'b0, 0);
        check("ramp_tail_valid", int'(o_valid), 0);

        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
